x9_issue_ctrl: RTL and testbench

Sequencing control unit that issues one 9-bit X9 instruction at a time to the datapath ALU. Accepts instructions over a valid/ready handshake, decodes the 4-bit opcode into the ALU command and register/immediate operand selects, runs memory handshakes for lb/sb, and commits results to the register file. Sits between instruction fetch and the ALU/regfile/data-memory; it drives the ALU and consumes its result and flag.

---
 rtl/x9_pkg.sv | 35 +++
 rtl/x9_instr_decode.sv | 55 +++++
 rtl/x9_issue_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_x9_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x9_pkg.sv
// Shared types and defaults for the X9 issue controller.
package x9_pkg;

  // Opcodes; values double as the ALU command encoding.
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_ADDI = 4'b0010,
    OP_LB   = 4'b0011,
    OP_SB   = 4'b0100,
    OP_MOVR = 4'b0101,
    OP_MOVI = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_AND  = 4'b1001,
    OP_OR   = 4'b1010,
    OP_SLL  = 4'b1011,
    OP_SLR  = 4'b1100,
    OP_EQ   = 4'b1101,
    OP_LT   = 4'b1110,
    OP_RXOR = 4'b1111
  } op_e;

  // Issue sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  // Cycles spent in MEM without an ack before the access is abandoned.
  localparam int unsigned X9_TIMEOUT = 255;

endpackage

// File: rtl/x9_instr_decode.sv
// Combinational X9 decode: ALU command, operand selects and class flags.
module x9_instr_decode
  import x9_pkg::*;
(
  input  logic [8:0] i_instr,
  output logic [3:0] o_alu_cmd,
  output logic [2:0] o_ra_addr,
  output logic [2:0] o_rb_addr,
  output logic [7:0] o_imm,
  output logic       o_b_sel,
  output logic       o_is_mem,
  output logic       o_is_load,
  output logic       o_is_flag,
  output logic       o_is_movi
);

  logic [2:0] w_rs;
  logic [2:0] w_rd;

  assign w_rs = i_instr[4:2];
  assign w_rd = {1'b0, i_instr[1:0]};

  // R-type selects are the default; other classes override what differs.
  always_comb begin
    o_alu_cmd = i_instr[8:5];
    o_ra_addr = w_rd;
    o_rb_addr = w_rs;
    o_imm     = '0;
    o_b_sel   = 1'b0;
    o_is_mem  = 1'b0;
    o_is_load = 1'b0;
    o_is_flag = 1'b0;
    o_is_movi = 1'b0;
    case (op_e'(i_instr[8:5]))
      OP_ADDI: begin
        o_imm   = {5'b0, w_rs};
        o_b_sel = 1'b1;
      end
      OP_LB: begin
        o_ra_addr = w_rs;
        o_is_mem  = 1'b1;
        o_is_load = 1'b1;
      end
      OP_SB: begin
        o_ra_addr = w_rs;
        o_rb_addr = w_rd;
        o_is_mem  = 1'b1;
      end
      OP_MOVI:      o_is_movi = 1'b1;
      OP_EQ, OP_LT: o_is_flag = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/x9_issue_ctrl.sv
// X9 issue controller: accepts one instruction, drives the ALU, runs lb/sb
// memory handshakes with a timeout, and commits results to the regfile.
module x9_issue_ctrl
  import x9_pkg::*;
#(
  parameter int unsigned TIMEOUT = X9_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  output logic [3:0] alu_cmd,
  output logic [2:0] ra_addr,
  output logic [2:0] rb_addr,
  output logic [7:0] imm,
  output logic       b_sel,
  input  logic [7:0] alu_rslt,
  input  logic       alu_one,
  input  logic [7:0] rb_data,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       wb_we,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       flag_q,
  output logic       busy,
  output logic       err
);

  state_e     r_state;
  state_e     w_state_nxt;

  logic [3:0] w_alu_cmd;
  logic [2:0] w_ra_addr;
  logic [2:0] w_rb_addr;
  logic [7:0] w_imm;
  logic       w_b_sel;
  logic       w_is_mem;
  logic       w_is_load;
  logic       w_is_flag;
  logic       w_is_movi;

  logic       w_accept;
  logic       w_tmo;

  logic [3:0] r_alu_cmd;
  logic [2:0] r_ra_addr;
  logic [2:0] r_rb_addr;
  logic [7:0] r_imm;
  logic       r_b_sel;
  logic       r_is_mem;
  logic       r_is_load;
  logic       r_is_flag;
  logic       r_is_movi;
  logic [2:0] r_rd;
  logic [4:0] r_movi_val;
  logic [7:0] r_tmo_cnt;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_mem_rd;
  logic       r_mem_wr;
  logic       r_wb_we;
  logic [2:0] r_wb_addr;
  logic [7:0] r_wb_data;
  logic       r_flag;
  logic       r_err;

  x9_instr_decode u_decode (
    .i_instr   (instr),
    .o_alu_cmd (w_alu_cmd),
    .o_ra_addr (w_ra_addr),
    .o_rb_addr (w_rb_addr),
    .o_imm     (w_imm),
    .o_b_sel   (w_b_sel),
    .o_is_mem  (w_is_mem),
    .o_is_load (w_is_load),
    .o_is_flag (w_is_flag),
    .o_is_movi (w_is_movi)
  );

  assign w_accept    = instr_valid && (r_state == ST_IDLE);
  assign w_tmo       = (r_tmo_cnt == 8'(TIMEOUT - 1));
  assign instr_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);

  assign alu_cmd   = r_alu_cmd;
  assign ra_addr   = r_ra_addr;
  assign rb_addr   = r_rb_addr;
  assign imm       = r_imm;
  assign b_sel     = r_b_sel;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign wb_we     = r_wb_we;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign flag_q    = r_flag;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state sequencing; an ack in the timeout cycle takes priority.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = r_is_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ack)    w_state_nxt = r_is_load ? ST_WB : ST_IDLE;
        else if (w_tmo) w_state_nxt = ST_IDLE;
      end
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered decode, memory strobes, writeback and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_cmd   <= '0;
      r_ra_addr   <= '0;
      r_rb_addr   <= '0;
      r_imm       <= '0;
      r_b_sel     <= 1'b0;
      r_is_mem    <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_flag   <= 1'b0;
      r_is_movi   <= 1'b0;
      r_rd        <= '0;
      r_movi_val  <= '0;
      r_tmo_cnt   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_flag      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_cmd  <= w_alu_cmd;
            r_ra_addr  <= w_ra_addr;
            r_rb_addr  <= w_rb_addr;
            r_imm      <= w_imm;
            r_b_sel    <= w_b_sel;
            r_is_mem   <= w_is_mem;
            r_is_load  <= w_is_load;
            r_is_flag  <= w_is_flag;
            r_is_movi  <= w_is_movi;
            r_rd       <= {1'b0, instr[1:0]};
            r_movi_val <= instr[4:0];
          end
        end
        ST_EXEC: begin
          if (r_is_mem) begin
            r_mem_addr <= alu_rslt;
            if (!r_is_load) r_mem_wdata <= rb_data;
            r_mem_rd   <= r_is_load;
            r_mem_wr   <= !r_is_load;
            r_tmo_cnt  <= '0;
            r_wb_addr  <= r_rd;
          end else begin
            r_wb_we <= 1'b1;
            if (r_is_movi) begin
              r_wb_addr <= '0;
              r_wb_data <= {3'b0, r_movi_val};
            end else begin
              r_wb_addr <= r_rd;
              r_wb_data <= alu_rslt;
            end
            if (r_is_flag) r_flag <= alu_one;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_is_load) begin
              r_wb_we   <= 1'b1;
              r_wb_data <= mem_rdata;
            end
          end else if (w_tmo) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_err    <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        ST_WB:   r_wb_we <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x9_issue_ctrl.sv
// Randomized self-checking bench for x9_issue_ctrl with regfile, ALU and
// memory environment models and an instruction-level reference model.
module tb_x9_issue_ctrl;

  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic [3:0] alu_cmd;
  logic [2:0] ra_addr;
  logic [2:0] rb_addr;
  logic [7:0] imm;
  logic       b_sel;
  logic [7:0] alu_rslt;
  logic       alu_one;
  logic [7:0] rb_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_rd;
  logic       mem_wr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flag_q;
  logic       busy;
  logic       err;

  // Environment state (driven by the DUT) and reference state (by the model).
  logic [7:0] R [8];
  logic [7:0] env_mem [256];
  logic [7:0] m_R [8];
  logic [7:0] m_mem [256];
  logic       m_flag;
  logic       m_err;

  logic       pre_r_we;
  logic       pre_m_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  int n_tests = 0;
  int n_fail  = 0;

  x9_issue_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_cmd     (alu_cmd),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .imm         (imm),
    .b_sel       (b_sel),
    .alu_rslt    (alu_rslt),
    .alu_one     (alu_one),
    .rb_data     (rb_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flag_q      (flag_q),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Regfile and data memory storage, with a bench preload port.
  always @(posedge clk) begin
    if (wb_we) R[wb_addr] <= wb_data;
    else if (pre_r_we) R[pre_addr[2:0]] <= pre_data;
    if (mem_wr && mem_ack) env_mem[mem_addr] <= mem_wdata;
    else if (pre_m_we) env_mem[pre_addr] <= pre_data;
  end

  assign mem_rdata = env_mem[mem_addr];
  assign alu_one   = alu_rslt[0];

  // ALU and regfile read port as seen by the DUT.
  always_comb begin
    logic [7:0] a, b;
    a        = R[ra_addr];
    b        = b_sel ? imm : R[rb_addr];
    rb_data  = R[rb_addr];
    alu_rslt = '0;
    case (alu_cmd)
      4'd0, 4'd2: alu_rslt = a + b;
      4'd1:       alu_rslt = a - b;
      4'd3, 4'd4: alu_rslt = a;
      4'd5, 4'd6: alu_rslt = b;
      4'd7:       alu_rslt = ~(a | b);
      4'd8:       alu_rslt = a ^ b;
      4'd9:       alu_rslt = a & b;
      4'd10:      alu_rslt = a | b;
      4'd11:      alu_rslt = a << b[2:0];
      4'd12:      alu_rslt = a >> b[2:0];
      4'd13:      alu_rslt = {7'b0, a == b};
      4'd14:      alu_rslt = {7'b0, a < b};
      default:    alu_rslt = {7'b0, ^b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural result of an ALU/movi instruction from the ISA rules.
  function automatic logic [7:0] ref_result(input logic [8:0] ins);
    logic [2:0] rs, rd;
    logic [7:0] x, y;
    rs = ins[4:2];
    rd = {1'b0, ins[1:0]};
    x  = m_R[rd];
    y  = m_R[rs];
    case (ins[8:5])
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x + {5'b0, rs};
      4'd5:    return y;
      4'd6:    return {3'b0, ins[4:0]};
      4'd7:    return ~(x | y);
      4'd8:    return x ^ y;
      4'd9:    return x & y;
      4'd10:   return x | y;
      4'd11:   return x << y[2:0];
      4'd12:   return x >> y[2:0];
      4'd13:   return (x == y) ? 8'd1 : 8'd0;
      4'd14:   return (x < y) ? 8'd1 : 8'd0;
      default: return {7'b0, ^y};
    endcase
  endfunction

  task automatic noise();
    instr_valid = 1'($urandom);
    instr       = 9'($urandom);
    mem_ack     = 1'($urandom);
  endtask

  task automatic pre_reg(input logic [2:0] a, input logic [7:0] d);
    pre_r_we = 1'b1; pre_addr = {5'b0, a}; pre_data = d;
    @(negedge clk);
    pre_r_we = 1'b0;
    m_R[a] = d;
  endtask

  task automatic pre_mem(input logic [7:0] a, input logic [7:0] d);
    pre_m_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_m_we = 1'b0;
    m_mem[a] = d;
  endtask

  // Issue one instruction and check its cycle-level behaviour; dly < 0 = no ack.
  task automatic do_instr(input logic [8:0] ins, input int dly);
    logic [3:0] op;
    logic [2:0] rs, rd, wa;
    logic [7:0] exp_d, ea;
    logic       ld, mop, acked;
    int         n, j, exp_cyc;
    op  = ins[8:5];
    rs  = ins[4:2];
    rd  = {1'b0, ins[1:0]};
    ld  = (op == 4'd3);
    mop = (op == 4'd3) || (op == 4'd4);
    n = 0;
    while (!instr_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    mem_ack     = 1'($urandom);
    @(negedge clk);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_ready", 32'(instr_ready), 32'd0);
    check("alu_cmd", 32'(alu_cmd), 32'(op));
    check("exec_wb_we", 32'(wb_we), 32'd0);
    noise();
    @(negedge clk);
    if (!mop) begin
      exp_d = ref_result(ins);
      wa    = (op == 4'd6) ? 3'd0 : rd;
      if (op == 4'd13 || op == 4'd14) m_flag = exp_d[0];
      check("wb_we", 32'(wb_we), 32'd1);
      check("wb_addr", 32'(wb_addr), 32'(wa));
      check("wb_data", 32'(wb_data), 32'(exp_d));
      check("wb_strobes", 32'({mem_rd, mem_wr}), 32'd0);
      check("wb_ready", 32'(instr_ready), 32'd0);
      check("flag_q", 32'(flag_q), 32'(m_flag));
      m_R[wa] = exp_d;
      noise();
      @(negedge clk);
    end else begin
      ea      = m_R[rs];
      exp_cyc = (dly >= 0 && dly < TMO) ? dly + 1 : TMO;
      check("mem_addr", 32'(mem_addr), 32'(ea));
      if (!ld) check("mem_wdata", 32'(mem_wdata), 32'(m_R[rd]));
      check("mem_rd", 32'(mem_rd), 32'(ld));
      check("mem_wr", 32'(mem_wr), 32'(!ld));
      j = 0;
      acked = 1'b0;
      while ((mem_rd || mem_wr) && j < 300) begin
        j++;
        check("mem_no_wb", 32'(wb_we), 32'd0);
        instr_valid = 1'($urandom);
        instr       = 9'($urandom);
        mem_ack     = (j == dly + 1);
        if (mem_ack) acked = 1'b1;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      check("mem_cycles", 32'(j), 32'(exp_cyc));
      if (acked && ld) begin
        check("lb_wb_we", 32'(wb_we), 32'd1);
        check("lb_wb_addr", 32'(wb_addr), 32'(rd));
        check("lb_wb_data", 32'(wb_data), 32'(m_mem[ea]));
        m_R[rd] = m_mem[ea];
        noise();
        mem_ack = 1'b0;
        @(negedge clk);
      end else if (acked) begin
        m_mem[ea] = m_R[rd];
      end else begin
        m_err = 1'b1;
      end
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    check("idle_ready", 32'(instr_ready), 32'd1);
    check("idle_wb_we", 32'(wb_we), 32'd0);
    check("idle_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nmis;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0;
    pre_r_we = 1'b0; pre_m_we = 1'b0; pre_addr = '0; pre_data = '0;
    m_flag = 1'b0; m_err = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) pre_mem(8'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) pre_reg(3'(i), 8'($urandom));
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flag_err", 32'({flag_q, err}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    // add R1 = 5 + 3
    pre_reg(3'd1, 8'd5);
    pre_reg(3'd2, 8'd3);
    do_instr(9'b0000_010_01, 0);
    // movi R0 = 0x15
    do_instr(9'b0110_10101, 0);
    // eq R0 == R3 then lt R3 < R3
    pre_reg(3'd0, 8'd7);
    pre_reg(3'd3, 8'd7);
    do_instr(9'b1101_011_00, 0);
    do_instr(9'b1110_011_11, 0);
    // lb with ack after 4 wait cycles, then sb
    pre_reg(3'd4, 8'h40);
    pre_mem(8'h40, 8'hA5);
    do_instr(9'b0011_100_10, 4);
    do_instr(9'b0100_100_01, 2);
    // ack exactly in the timeout cycle, then a true timeout
    do_instr(9'b0100_100_10, TMO - 1);
    do_instr(9'b0100_100_11, -1);
    do_instr(9'b0000_001_10, 0);

    for (int k = 0; k < 150; k++) begin
      do_instr(9'($urandom), int'($urandom_range(0, 5)));
    end

    // reset in the middle of an lb memory wait
    pre_reg(3'd5, 8'h80);
    instr_valid = 1'b1;
    instr = 9'b0011_101_01;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort_mem_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({mem_rd, mem_wr}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wb_we", 32'(wb_we), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    m_err = 1'b0;
    m_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_flag", 32'(flag_q), 32'd0);
    check("abort_no_wb", 32'(wb_we), 32'd0);

    for (int k = 0; k < 30; k++) begin
      do_instr(9'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 8; i++) check("regfile", 32'(R[i]), 32'(m_R[i]));
    nmis = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== m_mem[i]) nmis++;
    check("mem_image", 32'(nmis), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
